// File: rtl/nibble_serial_alu_ctrl.sv
// Multi-precision add/sub sequencer: one 4-bit slice per clock, LSB nibble first.
// Optional NIBBLE_ALU_CMP_EN adds registered unsigned/signed less-than outputs.
module nibble_serial_alu_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   subtract_enable,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  output logic [4*NIBBLES-1:0]   Res,
  output logic                   Cout,
  output logic                   Ovf,
  output logic                   Zero,
`ifdef NIBBLE_ALU_CMP_EN
  output logic                   lt_u,
  output logic                   lt_s,
`endif
  output logic                   busy,
  output logic                   done
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic                     carry;
  logic                     sub_q;
  logic [NIBBLES-1:0][3:0]  a_q, b_q, res_q, res_next;
  logic [3:0]               a_n, bx;
  logic [4:0]               sum5;
  logic                     last, ovf_n;

  assign Res  = res_q;
  assign last = (cnt == CW'(NIBBLES-1));

  // Single shared 4-bit slice; subtract is A + ~B + 1 with the +1 seeded into carry.
  always_comb begin
    a_n           = a_q[cnt];
    bx            = b_q[cnt] ^ {4{sub_q}};
    sum5          = {1'b0, a_n} + {1'b0, bx} + {4'b0, carry};
    res_next      = res_q;
    res_next[cnt] = sum5[3:0];
    ovf_n         = (a_n[3] == bx[3]) && (sum5[3] != a_n[3]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      Zero  <= 1'b0;
`ifdef NIBBLE_ALU_CMP_EN
      lt_u  <= 1'b0;
      lt_s  <= 1'b0;
`endif
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            sub_q <= subtract_enable;
            carry <= subtract_enable;
            cnt   <= '0;
            res_q <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          res_q <= res_next;
          carry <= sum5[4];
          if (last) begin
            Cout  <= sum5[4];
            Ovf   <= ovf_n;
            Zero  <= (res_next == '0);
`ifdef NIBBLE_ALU_CMP_EN
            lt_u  <= sub_q & ~sum5[4];
            lt_s  <= sub_q & (sum5[3] ^ ovf_n);
`endif
            cnt   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Directed bench for nibble_serial_alu_ctrl (NIBBLES=4): flags, latency, busy-start, async reset.
module tb_nibble_serial_alu_ctrl;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic [15:0] Res;
  logic        Cout, Ovf, Zero, busy, done;
`ifdef NIBBLE_ALU_CMP_EN
  logic        lt_u, lt_s;
`endif

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_alu_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .subtract_enable(sub),
    .A(A), .B(B), .Res(Res), .Cout(Cout), .Ovf(Ovf), .Zero(Zero),
`ifdef NIBBLE_ALU_CMP_EN
    .lt_u(lt_u), .lt_s(lt_s),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [15:0] res, input logic c, input logic o,
                        input logic z, input logic lu, input logic ls);
    int lat = 0;
    int bsy = 0;
    bit seen = 0;
    @(negedge clk);
    A = a; B = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; A = ~a; B = ~b; sub = ~s;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) bsy++;
      if (done) seen = 1'b1;
      else lat++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(N));
    chk("busy_cycles", 32'(bsy), 32'(N+1));
    chk("res", 32'(Res), 32'(res));
    chk("cout", 32'(Cout), 32'(c));
    chk("ovf", 32'(Ovf), 32'(o));
    chk("zero", 32'(Zero), 32'(z));
`ifdef NIBBLE_ALU_CMP_EN
    chk("lt_u", 32'(lt_u), 32'(lu));
    chk("lt_s", 32'(lt_s), 32'(ls));
`else
    if (lu === 1'bz || ls === 1'bz) $display("note: lt args unused");
`endif
    @(negedge clk);
    chk("res_hold", 32'(Res), 32'(res));
    chk("cout_hold", 32'(Cout), 32'(c));
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    #2;
    chk("rst_res", 32'(Res), 32'd0);
    chk("rst_flags", 32'({Cout, Ovf, Zero}), 32'd0);
    chk("rst_hs", 32'({busy, done}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_op(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // start held high through RUN and DONE must be ignored
    @(negedge clk);
    A = 16'h0001; B = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 A = 16'h5555;
    dn = 0;
    for (int i = 0; i < N+1; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_ign", 32'(busy), 32'd0);
    for (int i = 0; i < N+2; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("single_done", 32'(dn), 32'd1);
    chk("res_busy_start", 32'(Res), 32'h0002);
    run_op(16'h5555, 16'h1111, 1'b0, 16'h6666, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // async reset between edges on the second RUN cycle
    @(negedge clk);
    A = 16'h1234; B = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_res", 32'(Res), 32'd0);
    chk("mid_rst_flags", 32'({Cout, Ovf, Zero}), 32'd0);
    chk("mid_rst_hs", 32'({busy, done}), 32'd0);
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < N+2; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("no_done_after_rst", 32'(dn), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
